// File: rtl/divider_pkg.sv
// Shared constants, state type and saturation helper for the divider.
package divider_pkg;

    localparam int unsigned CDF_W    = 8;
    localparam int unsigned NUM_W    = 16;
    localparam int unsigned ITER_CNT = 16;
    localparam int unsigned SCALE    = 255;

    // Iteration counter width and trial-remainder width (divisor width plus the shifted-in bit)
    localparam int unsigned CNT_W = $clog2(ITER_CNT);
    localparam int unsigned REM_W = CDF_W + 1;

    typedef enum logic [1:0] {
        LOAD,
        ITER,
        DONE
    } state_e;

    // Clamp a widened quotient to the 8-bit output range
    function automatic logic [CDF_W-1:0] saturate(input logic [NUM_W:0] value);
        if (|value[NUM_W:CDF_W]) begin
            return '1;
        end
        return value[CDF_W-1:0];
    endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring-division step: shift a numerator bit into the partial remainder,
// trial-subtract the divisor, keep the difference when it does not go negative.
module divider_step
    import divider_pkg::*;
(
    input  logic [CDF_W-1:0] rem_i,
    input  logic             num_bit_i,
    input  logic [CDF_W-1:0] denom_i,
    output logic [CDF_W-1:0] rem_o,
    output logic             q_bit_o
);

    logic [REM_W-1:0] trial;

    assign trial   = {rem_i, num_bit_i};
    assign q_bit_o = (trial >= {1'b0, denom_i});
    // After a successful subtract the remainder is below the divisor, so it fits in CDF_W bits
    assign rem_o   = CDF_W'(q_bit_o ? (trial - {1'b0, denom_i}) : trial);

endmodule

// File: rtl/divider.sv
// Free-running normaliser: g_out = floor(cdf_in * 255 / DENOM), recomputed every
// 18 cycles (LOAD, 16 x ITER, DONE) with an iterative restoring divider.
// Optional macro DIVIDER_ROUND_EN: round to nearest (ties up) instead of truncating.
module divider
    import divider_pkg::*;
#(
    parameter logic [CDF_W-1:0] DENOM = 8'd16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CDF_W-1:0] cdf_in,
    output logic [CDF_W-1:0] g_out
);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [NUM_W-1:0] num_q;
    logic [CDF_W-1:0] rem_q;
    logic [NUM_W-1:0] quo_q;

    logic [CDF_W-1:0] step_rem;
    logic             step_q;
    logic             round_inc;
    logic [NUM_W:0]   quo_adj;
    logic [CDF_W-1:0] result;

    divider_step u_step (
        .rem_i     (rem_q),
        .num_bit_i (num_q[NUM_W-1]),
        .denom_i   (DENOM),
        .rem_o     (step_rem),
        .q_bit_o   (step_q)
    );

`ifdef DIVIDER_ROUND_EN
    // Round up when the final remainder is at least half the divisor
    assign round_inc = ({rem_q, 1'b0} >= {1'b0, DENOM});
`else
    assign round_inc = 1'b0;
`endif

    // Final result: optional rounding, then saturation; a zero divisor pins the output high
    always_comb begin
        quo_adj = {1'b0, quo_q} + {{NUM_W{1'b0}}, round_inc};
        if (DENOM == '0) begin
            result = '1;
        end else begin
            result = saturate(quo_adj);
        end
    end

    // Sequencer: LOAD captures the sample, ITER produces one quotient bit per cycle, DONE publishes
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            num_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            g_out   <= '0;
        end else begin
            unique case (state_q)
                LOAD: begin
                    num_q   <= NUM_W'(cdf_in) * NUM_W'(SCALE);
                    rem_q   <= '0;
                    quo_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= ITER;
                end
                ITER: begin
                    num_q <= {num_q[NUM_W-2:0], 1'b0};
                    rem_q <= step_rem;
                    quo_q <= {quo_q[NUM_W-2:0], step_q};
                    // Counter wraps back to zero on the last step
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITER_CNT - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    g_out   <= result;
                    state_q <= LOAD;
                end
                default: begin
                    state_q <= LOAD;
                end
            endcase
        end
    end

    // The output only moves on the DONE edge
    a_g_out_stable : assert property (
        @(posedge clk) disable iff (reset) (state_q != DONE) |=> $stable(g_out)
    );

    // The counter is idle outside ITER
    a_cnt_idle : assert property (
        @(posedge clk) disable iff (reset) (state_q != ITER) |-> (cnt_q == '0)
    );

endmodule

// File: tb/tb_divider.sv
// Bench for divider: three instances (DENOM = 16, 0, 255) on one clock and reset.
// Expected results are queued at each LOAD and compared on the DONE edge.
module tb_divider;

    logic       clk;
    logic       reset;
    logic [7:0] cdf16, cdf0, cdf255;
    logic [7:0] g16, g0, g255;

    int checks;
    int failures;

    logic [7:0] q16[$];
    logic [7:0] q0[$];
    logic [7:0] q255[$];
    logic [7:0] held16, held0, held255;

    divider #(.DENOM(8'd16)) dut16 (
        .clk    (clk),
        .reset  (reset),
        .cdf_in (cdf16),
        .g_out  (g16)
    );

    divider #(.DENOM(8'd0)) dut0 (
        .clk    (clk),
        .reset  (reset),
        .cdf_in (cdf0),
        .g_out  (g0)
    );

    divider #(.DENOM(8'd255)) dut255 (
        .clk    (clk),
        .reset  (reset),
        .cdf_in (cdf255),
        .g_out  (g255)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model(input int unsigned cdf, input int unsigned d);
        int unsigned n;
        int unsigned q;
        int unsigned r;
        if (d == 0) return 8'd255;
        n = cdf * 255;
        q = n / d;
        r = n % d;
`ifdef DIVIDER_ROUND_EN
        if (2 * r >= d) q = q + 1;
`endif
        if (q > 255) q = 255;
        return 8'(q);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full 18-edge period starting at a LOAD edge; optionally alter cdf16 after edge change_at
    task automatic run_period(input int change_at, input logic [7:0] new16);
        logic [7:0] e16, e0, e255;
        q16.push_back(model(cdf16, 16));
        q0.push_back(model(cdf0, 0));
        q255.push_back(model(cdf255, 255));
        for (int e = 1; e <= 17; e++) begin
            tick();
            if (e == change_at) cdf16 = new16;
            checks++;
            if ({g16, g0, g255} !== {held16, held0, held255}) begin
                failures++;
                $display("FAIL hold edge=%0d actual=%h/%h/%h required=%h/%h/%h",
                         e, g16, g0, g255, held16, held0, held255);
            end
        end
        tick();
        e16  = q16.pop_front();
        e0   = q0.pop_front();
        e255 = q255.pop_front();
        checks++;
        if (g16 !== e16) begin
            failures++;
            $display("FAIL result_denom16 actual=%0d required=%0d", g16, e16);
        end
        checks++;
        if (g0 !== e0) begin
            failures++;
            $display("FAIL result_denom0 actual=%0d required=%0d", g0, e0);
        end
        checks++;
        if (g255 !== e255) begin
            failures++;
            $display("FAIL result_denom255 actual=%0d required=%0d", g255, e255);
        end
        held16  = e16;
        held0   = e0;
        held255 = e255;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        cdf16  = 8'd1;
        cdf0   = 8'd10;
        cdf255 = 8'd200;
        tick();
        tick();
        checks++;
        if ({g16, g0, g255} !== 24'h0) begin
            failures++;
            $display("FAIL reset_state actual=%h/%h/%h required=00/00/00", g16, g0, g255);
        end
        held16  = 8'd0;
        held0   = 8'd0;
        held255 = 8'd0;
    endtask

    task automatic test_first_result();
        reset = 1'b0;
        run_period(-1, 8'd0);
        checks++;
        if (g16 !== model(1, 16)) begin
            failures++;
            $display("FAIL first_result actual=%0d required=%0d", g16, model(1, 16));
        end
    endtask

    task automatic test_input_ignored();
        run_period(3, 8'd4);
        run_period(-1, 8'd0);
    endtask

    task automatic test_saturation_zero();
        cdf16 = 8'd255;
        run_period(-1, 8'd0);
        cdf16 = 8'd0;
        run_period(-1, 8'd0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            cdf16  = 8'($urandom_range(0, 255));
            cdf0   = 8'($urandom_range(1, 255));
            cdf255 = 8'($urandom_range(0, 255));
            run_period(-1, 8'd0);
        end
    endtask

    task automatic test_reset_mid_iter();
        cdf16  = 8'd4;
        cdf0   = 8'd10;
        cdf255 = 8'd200;
        run_period(-1, 8'd0);
        for (int e = 1; e <= 6; e++) begin
            tick();
            checks++;
            if ({g16, g0, g255} !== {held16, held0, held255}) begin
                failures++;
                $display("FAIL pre_abort_hold edge=%0d actual=%h/%h/%h required=%h/%h/%h",
                         e, g16, g0, g255, held16, held0, held255);
            end
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({g16, g0, g255} !== 24'h0) begin
            failures++;
            $display("FAIL abort_clear actual=%h/%h/%h required=00/00/00", g16, g0, g255);
        end
        held16  = 8'd0;
        held0   = 8'd0;
        held255 = 8'd0;
        tick();
        cdf16 = 8'd2;
        reset = 1'b0;
        run_period(-1, 8'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_first_result();
        test_input_ignored();
        test_saturation_zero();
        test_random();
        test_reset_mid_iter();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter DENOM, default 16, meaning the 8-bit unsigned divisor (total count used for normalisation).
REQ-002 Port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 Port reset, input, 1, synchronous active-high reset, sampled on the rising clk edge.
REQ-004 Port cdf_in, input, 8, unsigned cumulative-count sample to be normalised.
REQ-005 Port g_out, output, 8, unsigned normalised result, registered and held between updates.

Function
REQ-006 The block SHALL compute g_out = floor(cdf_in * 255 / DENOM), unsigned, with a 16-bit numerator and an 8-bit divisor.
REQ-007 The block SHALL be a free-running iterative restoring divider with states LOAD, ITER and DONE, with no handshake.
REQ-008 In LOAD (1 cycle) the block SHALL capture cdf_in, form numerator = cdf_in*255, clear the remainder, and go to ITER.
REQ-009 ITER SHALL last exactly 16 cycles and produce one quotient bit per cycle, MSB first, using a 9-bit partial remainder.
REQ-010 In DONE (1 cycle) the block SHALL register the result into g_out and go to LOAD.
REQ-011 The full period SHALL be 18 cycles, and g_out SHALL change only on the DONE edge.
REQ-012 A change on cdf_in outside the LOAD cycle SHALL be ignored until the next LOAD.
REQ-013 If the 16-bit quotient exceeds 255, g_out SHALL saturate to 255.
REQ-014 If DENOM == 0, g_out SHALL be 255 on every DONE.
REQ-015 cdf_in == 0 SHALL yield g_out = 0.

Reset
REQ-016 While reset is high, the state SHALL be LOAD, g_out SHALL be 0, and the iteration counter, numerator, remainder and quotient SHALL be 0.
REQ-017 Reset asserted mid-ITER or mid-DONE SHALL abort the operation with no g_out update.
REQ-018 The first LOAD SHALL occur on the first rising edge with reset low, and the first g_out update SHALL occur 17 edges later.

Configuration
REQ-019 Macro DIVIDER_ROUND_EN: when defined, the result SHALL be rounded to nearest, with ties rounding up (a 1 is added to the quotient when 2*remainder >= DENOM, before saturation).
REQ-020 When DIVIDER_ROUND_EN is undefined, the result SHALL be truncated per REQ-006.

Structure
REQ-021 Package divider_pkg SHALL hold the constants CDF_W=8, NUM_W=16, ITER_CNT=16, SCALE=255 and the state enum type (LOAD, ITER, DONE).
REQ-022 One sub-module, divider_step, SHALL implement a single restoring step (shift in numerator bit, trial subtract, quotient bit out).
REQ-023 The top level SHALL hold the FSM, counter, registers, saturation and rounding logic.

Verification (DENOM=16)
REQ-024 Hold reset for 1 cycle with cdf_in=1, then release -> g_out=0 until the 18th edge after release, then g_out=15 (16 with DIVIDER_ROUND_EN).
REQ-025 Change cdf_in from 1 to 4 mid-ITER -> the current result stays 15; the next period gives g_out=63 (64 rounded).
REQ-026 cdf_in=255 -> g_out=255 (saturated); cdf_in=0 -> g_out=0.
REQ-027 Assert reset mid-ITER with g_out=63 -> g_out=0 on the next edge, and no stale result appears afterwards.
REQ-028 Set DENOM=0 with cdf_in=10 -> g_out=255; set DENOM=255 with cdf_in=200 -> g_out=200.
